// File: rtl/col_parity_restore_pkg.sv
// Shared widths, bit-index helper and FSM encoding for the column-parity restore block.
// No logic of its own.
// Imported by the restore datapath and its slice sub-module.
package col_parity_restore_pkg;

    localparam int SLICE_W = 25;
    localparam int PAR_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_STREAM,
        ST_WRAP,
        ST_DRAIN
    } state_t;

    function automatic int bit_idx(input int x, input int y);
        return x + 5 * y;
    endfunction

endpackage

// File: rtl/col_parity_restore_slice.sv
// Undo the column-parity mix on one slice and check the recovered column parities.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module col_parity_restore_slice
    import col_parity_restore_pkg::*;
(
    input  logic [SLICE_W-1:0] s,
    input  logic [PAR_W-1:0]   c,
    input  logic [PAR_W-1:0]   p,
    output logic [SLICE_W-1:0] r,
    output logic               mismatch
);

    logic [PAR_W-1:0] col;

    always_comb begin
        r   = '0;
        col = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                r[bit_idx(x, y)] = s[bit_idx(x, y)] ^ c[(x + 4) % 5] ^ p[(x + 1) % 5];
            end
        end
        // The restored slice must reproduce the parity it was restored with.
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                col[x] = col[x] ^ r[bit_idx(x, y)];
            end
        end
        mismatch = |(col ^ c);
    end

endmodule

// File: rtl/col_parity_restore.sv
// Recovers a theta-mixed state slice by slice; slice 0 is held and emitted last.
// Latency: 1 cycle from slice acceptance to out_valid.
// Backpressure: single output register; in_ready drops while the output is held.
module col_parity_restore
    import col_parity_restore_pkg::*;
#(
    parameter int NSLICE = 64,
    parameter int IDX_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SLICE_W-1:0] in_slice,
    input  logic [PAR_W-1:0]   in_par,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_slice,
    output logic [IDX_W-1:0]   out_index,
    output logic               busy,
    output logic               finish,
    output logic               parity_err
);

    state_t state_q, state_d;

    logic [IDX_W-1:0]   z_cnt;
    logic [SLICE_W-1:0] hold_slice;
    logic [PAR_W-1:0]   hold_par;
    logic [PAR_W-1:0]   prev_par;

    logic               out_free;
    logic               out_fire;
    logic               take_start;
    logic               take_first;
    logic               take_stream;
    logic               load_out;
    logic               wrap_sel;
    logic               done;

    logic [SLICE_W-1:0] rs_s;
    logic [PAR_W-1:0]   rs_c;
    logic [SLICE_W-1:0] rs_out;
    logic               rs_err;

    assign out_free = !out_valid || out_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        take_start  = 1'b0;
        take_first  = 1'b0;
        take_stream = 1'b0;
        load_out    = 1'b0;
        wrap_sel    = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    take_start = 1'b1;
                    state_d    = ST_FIRST;
                end
            end
            ST_FIRST: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    take_first = 1'b1;
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                in_ready = out_free;
                if (in_valid && out_free) begin
                    take_stream = 1'b1;
                    load_out    = 1'b1;
                    if (z_cnt == IDX_W'(NSLICE - 1)) begin
                        state_d = ST_WRAP;
                    end
                end
            end
            ST_WRAP: begin
                // Slice 0 needs C[.][NSLICE-1], only known once the last slice arrived.
                wrap_sel = 1'b1;
                if (out_free) begin
                    load_out = 1'b1;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rs_s = wrap_sel ? hold_slice : in_slice;
    assign rs_c = wrap_sel ? hold_par   : in_par;

    col_parity_restore_slice u_slice (
        .s        (rs_s),
        .c        (rs_c),
        .p        (prev_par),
        .r        (rs_out),
        .mismatch (rs_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            z_cnt      <= '0;
            hold_slice <= '0;
            hold_par   <= '0;
            prev_par   <= '0;
            out_valid  <= 1'b0;
            out_slice  <= '0;
            out_index  <= '0;
            busy       <= 1'b0;
            finish     <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            finish <= 1'b0;
            if (take_start) begin
                parity_err <= 1'b0;
                busy       <= 1'b1;
            end
            if (take_first) begin
                hold_slice <= in_slice;
                hold_par   <= in_par;
                prev_par   <= in_par;
                z_cnt      <= IDX_W'(1);
            end
            if (take_stream) begin
                prev_par <= in_par;
                z_cnt    <= z_cnt + IDX_W'(1);
            end
            if (load_out) begin
                out_slice <= rs_out;
                out_index <= wrap_sel ? '0 : z_cnt;
                out_valid <= 1'b1;
                if (rs_err) begin
                    parity_err <= 1'b1;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (done) begin
                busy   <= 1'b0;
                finish <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_col_parity_restore.sv
// Bench for col_parity_restore: theta-encodes states with a behavioural model and
// checks restored slices, ordering, stalls, parity errors, abort and stray starts.
module tb_col_parity_restore;

    localparam int NS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_slice;
    logic [4:0]  in_par;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_slice;
    logic [5:0]  out_index;
    logic        busy;
    logic        finish;
    logic        parity_err;

    int checks   = 0;
    int failures = 0;

    logic [24:0] orig [NS];
    logic [24:0] enc  [NS];
    logic [4:0]  cpar [NS];

    col_parity_restore #(.NSLICE(NS), .IDX_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_slice   (in_slice),
        .in_par     (in_par),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_slice  (out_slice),
        .out_index  (out_index),
        .busy       (busy),
        .finish     (finish),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: single set bit A[0][0][0]; mode 1: random state
    task automatic build(input int mode);
        for (int z = 0; z < NS; z++) begin
            orig[z] = (mode == 0) ? ((z == 0) ? 25'h1 : 25'h0) : 25'($urandom());
            cpar[z] = '0;
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    cpar[z][x] = cpar[z][x] ^ orig[z][x + 5 * y];
        end
        for (int z = 0; z < NS; z++)
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    enc[z][x + 5 * y] = orig[z][x + 5 * y] ^ cpar[z][(x + 4) % 5]
                                        ^ cpar[(z + NS - 1) % NS][(x + 1) % 5];
    endtask

    task automatic run_frame(input int rdy_pct, input int corrupt_z,
                             input int abort_after, input bit start_mid);
        int          sent = 0;
        int          got  = 0;
        int          fin  = 0;
        int          exp_z;
        bit          stall = 0;
        bit          aborted = 0;
        logic [24:0] held_s = '0;
        logic [5:0]  held_i = '0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_after_start", busy, 1);
        chk("err_cleared_on_start", parity_err, 0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            out_ready = ($urandom_range(99) < rdy_pct);
            in_valid  = (sent < NS) && (rdy_pct == 100 || $urandom_range(99) < 70);
            in_slice  = enc[sent % NS];
            in_par    = cpar[sent % NS] ^ ((sent == corrupt_z) ? 5'b00100 : 5'b00000);
            start     = start_mid && (sent == 30);
            #1;
            if (finish) begin
                chk("finish_after_all_outputs", got, NS);
                fin++;
                break;
            end
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_slice", out_slice, held_s);
                chk("stall_index", out_index, held_i);
            end
            if (out_valid && !out_ready)
                chk("in_ready_low_when_held", in_ready, 0);
            if (rdy_pct == 100 && sent < NS)
                chk("full_rate_in_ready", in_ready, 1);
            chk("parity_err_track", parity_err, (corrupt_z >= 0 && sent > corrupt_z));
            if (out_valid && out_ready) begin
                exp_z = (got < NS - 1) ? got + 1 : 0;
                chk("out_index_order", out_index, exp_z);
                if (corrupt_z < 0 || (exp_z != corrupt_z && exp_z != corrupt_z + 1))
                    chk("out_slice_data", out_slice, orig[exp_z]);
                got++;
            end
            if (in_valid && in_ready)
                sent++;
            stall  = out_valid && !out_ready;
            held_s = out_slice;
            held_i = out_index;
            @(negedge clk);
            if (abort_after > 0 && sent == abort_after) begin
                aborted = 1;
                break;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;

        if (aborted) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("abort_out_valid", out_valid, 0);
            chk("abort_in_ready", in_ready, 0);
            chk("abort_busy", busy, 0);
            chk("abort_out_slice", out_slice, 0);
            chk("abort_out_index", out_index, 0);
            chk("abort_parity_err", parity_err, 0);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                #1;
                chk("abort_no_finish", finish, 0);
                chk("abort_no_output", out_valid, 0);
            end
        end else begin
            chk("frame_finished", fin, 1);
            chk("output_count", got, NS);
            chk("busy_low_at_finish", busy, 0);
            chk("parity_err_at_finish", parity_err, (corrupt_z >= 0));
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                #1;
                chk("single_finish", finish, 0);
                chk("idle_no_output", out_valid, 0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_slice  = '0;
        in_par    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_slice", out_slice, 0);
        chk("reset_out_index", out_index, 0);
        chk("reset_busy", busy, 0);
        chk("reset_finish", finish, 0);
        chk("reset_parity_err", parity_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        build(0);
        chk("model_single_bit_slice0", enc[0], 25'h0210843);
        chk("model_single_bit_slice1", enc[1], 25'h1084210);
        run_frame(100, -1, 0, 0);

        build(1);
        run_frame(100, -1, 0, 0);

        build(1);
        run_frame(50, -1, 0, 0);

        build(1);
        run_frame(50, 10, 0, 0);

        build(1);
        run_frame(100, -1, 0, 0);

        build(1);
        run_frame(50, -1, 20, 0);
        run_frame(100, -1, 0, 0);

        build(1);
        run_frame(50, -1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
